// File: rtl/udp_decoder.sv
// UDP header parser and checksum checker.
// Consumes the IP payload word stream, captures the 8-byte UDP header,
// forwards payload words with trailing bytes masked, and verifies the UDP
// checksum against the IPv4 pseudo-header. Reports completion on fin/ok.
module udp_decoder #(
  parameter logic [7:0] PROTO_UDP = 8'd17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        start,
  input  logic [31:0] src_ip,
  input  logic [31:0] dest_ip,
  output logic [15:0] src_port,
  output logic [15:0] dest_port,
  output logic [15:0] udp_length,
  output logic [15:0] udp_chksum,
  output logic [15:0] len_out,
  output logic [31:0] data_out,
  output logic        wr_en,
  output logic        ok,
  output logic        fin
);

  typedef enum logic [2:0] {
    IDLE,
    HDR2,
    PAYLOAD,
    DONE_CHK,
    DONE_BAD,
    WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] cnt_q, cnt_d;

  logic [15:0] src_port_d, dest_port_d, udp_length_d, udp_chksum_d, len_out_d;
  logic [31:0] data_out_d;
  logic        wr_en_d, ok_d, fin_d;

  logic [15:0] word_hi, word_lo;
  logic [31:0] pseudo_sum;
  logic [15:0] remaining;
  logic        last_word;
  logic [31:0] masked;
  logic [16:0] fold1;
  logic [15:0] fold2;

  assign word_hi = data[31:16];
  assign word_lo = data[15:0];

  // Pseudo-header (addresses, protocol) plus the first header word
  assign pseudo_sum = 32'(src_ip[31:16]) + 32'(src_ip[15:0])
                    + 32'(dest_ip[31:16]) + 32'(dest_ip[15:0])
                    + 32'(PROTO_UDP) + 32'(word_hi) + 32'(word_lo);

  // Bytes still owed by the datagram; only meaningful in PAYLOAD where cnt < len_out
  assign remaining = len_out - cnt_q;
  assign last_word = (17'(cnt_q) + 17'd4) >= 17'(len_out);

  // Zero the bytes of the final word that lie beyond the UDP length
  always_comb begin
    masked = data;
    case (remaining)
      16'd1:   masked = {data[31:24], 24'h0};
      16'd2:   masked = {data[31:16], 16'h0};
      16'd3:   masked = {data[31:8], 8'h0};
      default: masked = data;
    endcase
  end

  // One's-complement fold of the 32-bit accumulator down to 16 bits
  always_comb begin
    fold1 = 17'(acc_q[31:16]) + 17'(acc_q[15:0]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HDR2;
      HDR2: begin
        if (!start)                state_d = DONE_BAD;
        else if (word_hi < 16'd8)  state_d = DONE_BAD;
        else if (word_hi == 16'd8) state_d = DONE_CHK;
        else                       state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (!start)        state_d = DONE_BAD;
        else if (last_word) state_d = DONE_CHK;
      end
      DONE_CHK: state_d = WAIT;
      DONE_BAD: state_d = WAIT;
      WAIT:     if (!start) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs, accumulator and byte counter
  always_comb begin
    src_port_d   = src_port;
    dest_port_d  = dest_port;
    udp_length_d = udp_length;
    udp_chksum_d = udp_chksum;
    len_out_d    = len_out;
    data_out_d   = data_out;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    wr_en_d      = 1'b0;
    ok_d         = 1'b0;
    fin_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_port_d  = word_hi;
          dest_port_d = word_lo;
          acc_d       = pseudo_sum;
        end
      end
      HDR2: begin
        if (start) begin
          udp_length_d = word_hi;
          udp_chksum_d = word_lo;
          len_out_d    = word_hi - 16'd8;
          // Length appears in both the pseudo-header and the UDP header
          acc_d        = acc_q + 32'(word_hi) + 32'(word_hi) + 32'(word_lo);
          cnt_d        = '0;
        end
      end
      PAYLOAD: begin
        if (start) begin
          data_out_d = masked;
          wr_en_d    = 1'b1;
          acc_d      = acc_q + 32'(masked[31:16]) + 32'(masked[15:0]);
          cnt_d      = cnt_q + 16'd4;
        end
      end
      DONE_CHK: begin
        fin_d = 1'b1;
        ok_d  = (fold2 == 16'hFFFF) || (udp_chksum == '0);
      end
      DONE_BAD: fin_d = 1'b1;
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_port   <= '0;
      dest_port  <= '0;
      udp_length <= '0;
      udp_chksum <= '0;
      len_out    <= '0;
      data_out   <= '0;
      wr_en      <= 1'b0;
      ok         <= 1'b0;
      fin        <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      src_port   <= src_port_d;
      dest_port  <= dest_port_d;
      udp_length <= udp_length_d;
      udp_chksum <= udp_chksum_d;
      len_out    <= len_out_d;
      data_out   <= data_out_d;
      wr_en      <= wr_en_d;
      ok         <= ok_d;
      fin        <= fin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
